// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
// Module      : video_pkg
// Description : Shared definitions for the video capture path: capture FSM
//               state encoding, luma coefficients and default window geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package video_pkg;

    // Capture controller states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_CAPTURE = 2'd2
    } cap_state_t;

    // Luma weights, scaled by 256 (77 + 150 + 29 = 256)
    localparam logic [7:0] c_luma_r = 8'd77;
    localparam logic [7:0] c_luma_g = 8'd150;
    localparam logic [7:0] c_luma_b = 8'd29;

    // Default capture window inside a 1280x720 active picture
    localparam logic [11:0] c_win_x_start = 12'd640;
    localparam logic [11:0] c_win_y_start = 12'd412;
    localparam logic [11:0] c_win_size    = 12'd256;

endpackage : video_pkg
`default_nettype wire

// File: rtl/rgb2gray.sv
`default_nettype none
// ============================================================================
// Module      : rgb2gray
// Description : One-stage registered luma converter.
//               Y = (77*R + 150*G + 29*B) >> 8, 16-bit multiply-add, result
//               truncated to COLOR_DEPTH and replicated into R, G and B.
// Ports       : pix_clk - pixel clock
//               rstn    - asynchronous active-low reset
//               i_rgb   - RGB input, R in the MSBs
//               o_gray  - registered {Y, Y, Y}
// Revision    : 1.0 - initial release
// ============================================================================
module rgb2gray
    import video_pkg::*;
#(
    parameter int COLOR_DEPTH = 8
) (
    input  logic                       pix_clk,
    input  logic                       rstn,
    input  logic [3*COLOR_DEPTH-1:0]   i_rgb,
    output logic [3*COLOR_DEPTH-1:0]   o_gray
);

    logic [COLOR_DEPTH-1:0] w_r;
    logic [COLOR_DEPTH-1:0] w_g;
    logic [COLOR_DEPTH-1:0] w_b;
    logic [15:0]            w_sum;
    logic [15:0]            w_shift;
    logic [COLOR_DEPTH-1:0] w_y;
    logic [3*COLOR_DEPTH-1:0] r_gray;

    assign w_r = i_rgb[3*COLOR_DEPTH-1 -: COLOR_DEPTH];
    assign w_g = i_rgb[2*COLOR_DEPTH-1 -: COLOR_DEPTH];
    assign w_b = i_rgb[COLOR_DEPTH-1   -: COLOR_DEPTH];

    assign w_sum   = 16'(c_luma_r) * 16'(w_r)
                   + 16'(c_luma_g) * 16'(w_g)
                   + 16'(c_luma_b) * 16'(w_b);
    assign w_shift = w_sum >> 8;
    assign w_y     = w_shift[COLOR_DEPTH-1:0];

    always_ff @(posedge pix_clk or negedge rstn) begin
        if (!rstn) begin
            r_gray <= '0;
        end else begin
            r_gray <= {3{w_y}};
        end
    end

    assign o_gray = r_gray;

endmodule : rgb2gray
`default_nettype wire

// File: rtl/video_window_capture.sv
`default_nettype none
// ============================================================================
// Module      : video_window_capture
// Description : Captures a WIN_WIDTH x WIN_HEIGHT window of one full video
//               frame into a single-port RAM, row-major, address 0 = top-left.
//               One frame per capture_req; aborts on an early vsync edge.
// Ports       : pix_clk, rstn (async, active-low)
//               vs_in/hs_in/de_in/pixel_in - video input (hs_in unused)
//               capture_req                - single-cycle capture request
//               ram_we/ram_addr/ram_wr_data - RAM write port (registered)
//               busy, frame_done, frame_err - handshake/status
// Options     : CAPTURE_GRAY_EN - write luma {Y,Y,Y} instead of RGB; adds one
//               pipeline stage to data, we, addr, frame_done and frame_err.
// Revision    : 1.0 - initial release
// ============================================================================
module video_window_capture
    import video_pkg::*;
#(
    parameter int                 COLOR_DEPTH = 8,
    parameter int                 X_BITS      = 12,
    parameter int                 Y_BITS      = 12,
    parameter logic [X_BITS-1:0]  WIN_X_START = c_win_x_start,
    parameter logic [Y_BITS-1:0]  WIN_Y_START = c_win_y_start,
    parameter logic [X_BITS-1:0]  WIN_WIDTH   = c_win_size,
    parameter logic [Y_BITS-1:0]  WIN_HEIGHT  = c_win_size,
    parameter int                 ADDR_BITS   = 16,
    parameter logic               VS_POL      = 1'b1
) (
    input  logic                       pix_clk,
    input  logic                       rstn,
    input  logic                       vs_in,
    input  logic                       hs_in,
    input  logic                       de_in,
    input  logic [3*COLOR_DEPTH-1:0]   pixel_in,
    input  logic                       capture_req,
    output logic                       ram_we,
    output logic [ADDR_BITS-1:0]       ram_addr,
    output logic [3*COLOR_DEPTH-1:0]   ram_wr_data,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       frame_err
);

    localparam int unsigned          N_PIX     = 32'(WIN_WIDTH) * 32'(WIN_HEIGHT);
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(N_PIX - 1);
    localparam logic [X_BITS:0]      X_LO      = {1'b0, WIN_X_START};
    localparam logic [X_BITS:0]      X_HI      = {1'b0, WIN_X_START} + {1'b0, WIN_WIDTH};
    localparam logic [Y_BITS:0]      Y_LO      = {1'b0, WIN_Y_START};
    localparam logic [Y_BITS:0]      Y_HI      = {1'b0, WIN_Y_START} + {1'b0, WIN_HEIGHT};

    // Horizontal sync carries no information needed for positioning
    logic w_unused_hs;
    assign w_unused_hs = hs_in;

    // ------------------------------------------------------------------
    // Position tracking
    // ------------------------------------------------------------------
    logic              r_vs_d;
    logic              r_de_d;
    logic [X_BITS-1:0] r_x_cnt;
    logic [Y_BITS-1:0] r_y_cnt;
    logic              w_vs_edge;
    logic              w_de_fall;
    logic              w_in_win;

    assign w_vs_edge = (vs_in == VS_POL) && (r_vs_d != VS_POL);
    assign w_de_fall = r_de_d && !de_in;
    assign w_in_win  = de_in
                    && ({1'b0, r_x_cnt} >= X_LO) && ({1'b0, r_x_cnt} < X_HI)
                    && ({1'b0, r_y_cnt} >= Y_LO) && ({1'b0, r_y_cnt} < Y_HI);

    // r_vs_d resets to the active level so a vsync already asserted when
    // reset is released is not mistaken for a fresh frame start.
    always_ff @(posedge pix_clk or negedge rstn) begin
        if (!rstn) begin
            r_vs_d  <= VS_POL;
            r_de_d  <= 1'b0;
            r_x_cnt <= '0;
            r_y_cnt <= '0;
        end else begin
            r_vs_d <= vs_in;
            r_de_d <= de_in;
            if (w_vs_edge) begin
                r_x_cnt <= '0;
                r_y_cnt <= '0;
            end else if (w_de_fall) begin
                r_x_cnt <= '0;
                r_y_cnt <= r_y_cnt + 1'b1;
            end else if (de_in) begin
                r_x_cnt <= r_x_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Capture controller
    // ------------------------------------------------------------------
    cap_state_t           r_state;
    cap_state_t           w_state_nxt;
    logic                 w_start;
    logic                 w_wr;
    logic                 w_done;
    logic                 w_err;
    logic [ADDR_BITS-1:0] r_waddr;

    always_ff @(posedge pix_clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_wr        = 1'b0;
        w_done      = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A vsync edge in the request cycle only arms; the
                // capture begins at the following frame start.
                if (capture_req) begin
                    w_state_nxt = ST_ARM;
                end
            end
            ST_ARM: begin
                if (w_vs_edge) begin
                    w_state_nxt = ST_CAPTURE;
                    w_start     = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (w_vs_edge) begin
                    // New frame before the window completed
                    w_err       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_in_win) begin
                    w_wr = 1'b1;
                    if (r_waddr == LAST_ADDR) begin
                        w_done      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign busy = (r_state != ST_IDLE);

    // ------------------------------------------------------------------
    // Write port, first register stage
    // ------------------------------------------------------------------
    logic                       r_we;
    logic [ADDR_BITS-1:0]       r_addr;
    logic [3*COLOR_DEPTH-1:0]   r_data;
    logic                       r_done;
    logic                       r_err;

    always_ff @(posedge pix_clk or negedge rstn) begin
        if (!rstn) begin
            r_waddr <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (w_start) begin
                r_waddr <= '0;
            end else if (w_wr) begin
                r_waddr <= r_waddr + 1'b1;
            end
            r_we   <= w_wr;
            r_done <= w_done;
            r_err  <= w_err;
            if (w_wr) begin
                r_addr <= r_waddr;
                r_data <= pixel_in;
            end
        end
    end

`ifdef CAPTURE_GRAY_EN
    // ------------------------------------------------------------------
    // Grayscale: luma stage on the data, matching delay on the controls
    // ------------------------------------------------------------------
    logic [3*COLOR_DEPTH-1:0]   w_gray;
    logic                       r2_we;
    logic [ADDR_BITS-1:0]       r2_addr;
    logic                       r2_done;
    logic                       r2_err;

    rgb2gray #(
        .COLOR_DEPTH (COLOR_DEPTH)
    ) u_rgb2gray (
        .pix_clk (pix_clk),
        .rstn    (rstn),
        .i_rgb   (r_data),
        .o_gray  (w_gray)
    );

    always_ff @(posedge pix_clk or negedge rstn) begin
        if (!rstn) begin
            r2_we   <= 1'b0;
            r2_addr <= '0;
            r2_done <= 1'b0;
            r2_err  <= 1'b0;
        end else begin
            r2_we   <= r_we;
            r2_addr <= r_addr;
            r2_done <= r_done;
            r2_err  <= r_err;
        end
    end

    assign ram_we      = r2_we;
    assign ram_addr    = r2_addr;
    assign ram_wr_data = w_gray;
    assign frame_done  = r2_done;
    assign frame_err   = r2_err;
`else
    assign ram_we      = r_we;
    assign ram_addr    = r_addr;
    assign ram_wr_data = r_data;
    assign frame_done  = r_done;
    assign frame_err   = r_err;
`endif

endmodule : video_window_capture
`default_nettype wire

// File: tb/tb_video_window_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_video_window_capture
// Description : Self-checking bench for video_window_capture using a reduced
//               geometry: 8 active pixels per line, window x 2..5, y 1..3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_video_window_capture;

    localparam int CD    = 8;
    localparam int AB    = 4;
    localparam int WXS   = 2;
    localparam int WYS   = 1;
    localparam int WW    = 4;
    localparam int WH    = 3;
    localparam int NPIX  = WW * WH;
    localparam int H_ACT = 8;
`ifdef CAPTURE_GRAY_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic            clk;
    logic            rstn;
    logic            vs_in;
    logic            hs_in;
    logic            de_in;
    logic [3*CD-1:0] pixel_in;
    logic            capture_req;
    logic            ram_we;
    logic [AB-1:0]   ram_addr;
    logic [3*CD-1:0] ram_wr_data;
    logic            busy;
    logic            frame_done;
    logic            frame_err;

    video_window_capture #(
        .COLOR_DEPTH (CD),
        .X_BITS      (12),
        .Y_BITS      (12),
        .WIN_X_START (12'd2),
        .WIN_Y_START (12'd1),
        .WIN_WIDTH   (12'd4),
        .WIN_HEIGHT  (12'd3),
        .ADDR_BITS   (AB),
        .VS_POL      (1'b1)
    ) dut (
        .pix_clk     (clk),
        .rstn        (rstn),
        .vs_in       (vs_in),
        .hs_in       (hs_in),
        .de_in       (de_in),
        .pixel_in    (pixel_in),
        .capture_req (capture_req),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wr_data (ram_wr_data),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_err   (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int lines;     // active lines in the captured frame
        int req;       // line of the arming frame carrying capture_req (-2: on vs edge)
        int exp_wr;
        int exp_done;
        int exp_err;
    } scen_t;

    scen_t tbl [5];

    int total;
    int bad;
    int cyc;
    int exp_idx;
    int done_cnt;
    int err_cnt;
    int lat_drv;
    int lat_we;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] exp_pix(input int k);
        logic [7:0]  y;
        logic [7:0]  x;
        logic [15:0] s;
        y = 8'(WYS + k / WW);
        x = 8'(WXS + k % WW);
        s = 16'(77 * int'(y) + 150 * int'(x));
`ifdef CAPTURE_GRAY_EN
        return {3{s[15:8]}};
`else
        return {y, x, 8'h00};
`endif
    endfunction

    // Sample outputs 1 time unit after the active edge and score writes
    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        if (ram_we) begin
            if (exp_idx == 0) lat_we = cyc;
            chk("wr_addr", longint'(ram_addr), longint'(exp_idx % 16));
            chk("wr_data", longint'(ram_wr_data), longint'(exp_pix(exp_idx)));
            exp_idx++;
        end
        if (frame_done) begin
            done_cnt++;
            chk("done_with_we", longint'(ram_we), 1);
            chk("done_addr", longint'(ram_addr), NPIX - 1);
        end
        if (frame_err) begin
            err_cnt++;
            chk("err_no_we", longint'(ram_we), 0);
        end
    endtask

    task automatic reset_sb();
        exp_idx  = 0;
        done_cnt = 0;
        err_cnt  = 0;
        lat_drv  = -1;
        lat_we   = -1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_we"},    longint'(ram_we), 0);
        chk({tag, "_addr"},  longint'(ram_addr), 0);
        chk({tag, "_data"},  longint'(ram_wr_data), 0);
        chk({tag, "_busy"},  longint'(busy), 0);
        chk({tag, "_done"},  longint'(frame_done), 0);
        chk({tag, "_err"},   longint'(frame_err), 0);
    endtask

    // One frame: vsync pulse, then `lines` active lines of H_ACT pixels.
    task automatic frame(input int lines, input int req_line, input int rst_line, input bit mark);
        vs_in = 1'b1;
        if (req_line == -2) capture_req = 1'b1;
        cycle();
        capture_req = 1'b0;
        cycle();
        vs_in = 1'b0;
        cycle();
        cycle();
        for (int l = 0; l < lines; l++) begin
            for (int x = 0; x < H_ACT; x++) begin
                de_in       = 1'b1;
                pixel_in    = {l[7:0], x[7:0], 8'h00};
                capture_req = (l == req_line) && (x == 0);
                if (mark && l == WYS && x == WXS && lat_drv < 0) lat_drv = cyc;
                if (l == rst_line && x == 3) begin
                    #2;
                    rstn = 1'b0;
                    #1;
                    chk_all_zero("async_rst");
                end
                cycle();
            end
            capture_req = 1'b0;
            de_in       = 1'b0;
            pixel_in    = '0;
            if (l == rst_line) rstn = 1'b1;
            repeat (3) cycle();
        end
        repeat (2) cycle();
    endtask

    initial begin
        tbl[0] = '{lines: 6, req: 2,  exp_wr: NPIX, exp_done: 1, exp_err: 0};
        tbl[1] = '{lines: 3, req: 4,  exp_wr: 8,    exp_done: 0, exp_err: 1};
        tbl[2] = '{lines: 1, req: 0,  exp_wr: 0,    exp_done: 0, exp_err: 1};
        tbl[3] = '{lines: 4, req: 5,  exp_wr: NPIX, exp_done: 1, exp_err: 0};
        tbl[4] = '{lines: 6, req: -2, exp_wr: NPIX, exp_done: 1, exp_err: 0};

        total = 0;
        bad   = 0;
        cyc   = 0;
        reset_sb();

        rstn        = 1'b0;
        vs_in       = 1'b0;
        hs_in       = 1'b0;
        de_in       = 1'b0;
        pixel_in    = '0;
        capture_req = 1'b0;
        repeat (3) cycle();
        chk_all_zero("reset");
        rstn = 1'b1;
        repeat (2) cycle();
        chk("idle_busy", longint'(busy), 0);

        // Table-driven scenarios: arming frame, capture frame, trailing frame
        for (int i = 0; i < 5; i++) begin
            reset_sb();
            frame(6, tbl[i].req, -1, 1'b0);
            chk("arm_no_writes", exp_idx, 0);
            chk("armed_busy", longint'(busy), 1);
            frame(tbl[i].lines, -1, -1, 1'b1);
            frame(6, -1, -1, 1'b0);
            chk("writes", exp_idx, tbl[i].exp_wr);
            chk("done_cnt", done_cnt, tbl[i].exp_done);
            chk("err_cnt", err_cnt, tbl[i].exp_err);
            chk("end_busy", longint'(busy), 0);
            if (tbl[i].exp_wr > 0) chk("latency", lat_we - lat_drv, LAT);
        end

        // busy rises the cycle after the request; a second request while
        // busy is dropped, a request after frame_done captures again from 0
        reset_sb();
        capture_req = 1'b1;
        cycle();
        capture_req = 1'b0;
        chk("busy_rise", longint'(busy), 1);
        frame(6, 2, -1, 1'b1);
        frame(6, -1, -1, 1'b0);
        chk("busy_req_writes", exp_idx, NPIX);
        chk("busy_req_done", done_cnt, 1);
        reset_sb();
        frame(6, 2, -1, 1'b0);
        frame(6, -1, -1, 1'b1);
        frame(6, -1, -1, 1'b0);
        chk("recapture_writes", exp_idx, NPIX);
        chk("recapture_done", done_cnt, 1);

        // Reset in the middle of a capture, then a fresh capture from 0
        reset_sb();
        frame(6, 2, -1, 1'b0);
        frame(6, -1, 2, 1'b0);
        chk("rst_partial_writes", exp_idx, 6 - LAT);
        chk("rst_no_done", done_cnt, 0);
        chk("rst_busy", longint'(busy), 0);
        reset_sb();
        frame(6, 2, -1, 1'b0);
        frame(6, -1, -1, 1'b1);
        frame(6, -1, -1, 1'b0);
        chk("post_rst_writes", exp_idx, NPIX);
        chk("post_rst_done", done_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_video_window_capture
`default_nettype wire
